latch_bank: RTL and testbench

//  Parametrised bank of CH channels x W-bit latches, simulated in the 'clock'

---
 rtl/latch_bank_pkg.sv | 22 ++
 rtl/latch_bank_if.sv | 28 ++
 rtl/latch_bank_ch.sv | 72 +++++++
 rtl/latch_bank.sv | 37 +++
 tb/tb_latch_bank.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/latch_bank_pkg.sv
// Shared definitions for the latch_bank channel array: mode encodings and the
// per-bit set/reset/gate priority mux used by both channel modes.
package latch_bank_pkg;

  localparam logic MODE_TRANSPARENT = 1'b0;
  localparam logic MODE_FLOP        = 1'b1;

  // Reset beats set, set beats gated data, otherwise the bit keeps its value.
  function automatic logic latch_next(input logic s, input logic r,
                                      input logic g, input logic d,
                                      input logic hold);
    if (r)
      return 1'b0;
    else if (s)
      return 1'b1;
    else if (g)
      return d;
    else
      return hold;
  endfunction

endpackage

// File: rtl/latch_bank_if.sv
// Bus bundle for latch_bank: per-bit set/reset/data, per-channel gates and the
// bank outputs (q, closed/changed strobes, hold-age).
interface latch_bank_if #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int AGE_W = 4
);

  logic [CH*W-1:0]     s;
  logic [CH*W-1:0]     r;
  logic [CH-1:0]       g;
  logic [CH*W-1:0]     d;
  logic [CH*W-1:0]     q;
  logic [CH-1:0]       closed;
  logic [CH-1:0]       changed;
  logic [CH*AGE_W-1:0] age;

  modport master (
    output s, r, g, d,
    input  q, closed, changed, age
  );

  modport slave (
    input  s, r, g, d,
    output q, closed, changed, age
  );

endinterface

// File: rtl/latch_bank_ch.sv
// One latch_bank channel: transparent latch or gated flop, with close/change
// strobes and an optional saturating hold-age counter (LATCH_BANK_AGE_EN).
module latch_bank_ch
  import latch_bank_pkg::*;
#(
  parameter int           W      = 8,
  parameter logic         MODE_C = MODE_TRANSPARENT,
  parameter logic [W-1:0] INIT_C = '0,
  parameter int           AGE_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     s,
  input  logic [W-1:0]     r,
  input  logic             g,
  input  logic [W-1:0]     d,
  output logic [W-1:0]     q,
  output logic             closed,
  output logic             changed,
  output logic [AGE_W-1:0] age
);

  logic [W-1:0] val;
  logic [W-1:0] next_val;
  logic         g_d;

  always_comb begin
    next_val = val;
    for (int b = 0; b < W; b++)
      next_val[b] = latch_next(s[b], r[b], g, d[b], val[b]);
  end

  // A transparent channel shows the mux output right away and stores it at the
  // edge; a flop channel only shows what was stored. Reset forces INIT either way.
  assign q = reset ? INIT_C : ((MODE_C == MODE_TRANSPARENT) ? next_val : val);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      val     <= INIT_C;
      g_d     <= 1'b0;
      closed  <= 1'b0;
      changed <= 1'b0;
    end else begin
      val     <= next_val;
      g_d     <= g;
      closed  <= g_d & ~g;
      changed <= (next_val != val);
    end
  end

`ifdef LATCH_BANK_AGE_EN
  logic             load;
  logic [AGE_W-1:0] age_q;

  assign load = g | (|s) | (|r);

  // Counts edges since the last load and sticks at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      age_q <= '0;
    else if (load)
      age_q <= '0;
    else if (age_q != '1)
      age_q <= age_q + 1'b1;
  end

  assign age = age_q;
`else
  assign age = '0;
`endif

endmodule

// File: rtl/latch_bank.sv
// Bank of CH latch channels sliced out of one bus interface.
// Optional hold-age counters are enabled with LATCH_BANK_AGE_EN.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int                CH    = 4,
  parameter int                W     = 8,
  parameter logic [CH-1:0]     MODE  = '0,
  parameter logic [CH*W-1:0]   INIT  = '0,
  parameter int                AGE_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  latch_bank_if.slave bus
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    latch_bank_ch #(
      .W      (W),
      .MODE_C (MODE[c]),
      .INIT_C (INIT[c*W +: W]),
      .AGE_W  (AGE_W)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .s       (bus.s[c*W +: W]),
      .r       (bus.r[c*W +: W]),
      .g       (bus.g[c]),
      .d       (bus.d[c*W +: W]),
      .q       (bus.q[c*W +: W]),
      .closed  (bus.closed[c]),
      .changed (bus.changed[c]),
      .age     (bus.age[c*AGE_W +: AGE_W])
    );
  end

endmodule

// File: tb/tb_latch_bank.sv
// Self-checking bench for latch_bank: directed scenarios plus randomized
// traffic against a word-level reference model of the bank.
module tb_latch_bank;

  localparam int              CH    = 4;
  localparam int              W     = 8;
  localparam int              AGE_W = 4;
  localparam logic [CH-1:0]   MODE  = 4'b1010;
  localparam logic [CH*W-1:0] INIT  = 32'h1E005AA5;
  localparam int              AGE_MAX = (1 << AGE_W) - 1;

  logic clock = 1'b0;
  logic reset;

  latch_bank_if #(.CH(CH), .W(W), .AGE_W(AGE_W)) bus ();

  latch_bank #(
    .CH(CH), .W(W), .MODE(MODE), .INIT(INIT), .AGE_W(AGE_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [W-1:0]  m_val [CH];
  logic          m_gd  [CH];
  logic [CH-1:0] m_closed;
  logic [CH-1:0] m_changed;
  int            m_age [CH];
  int            checks = 0;
  int            errors = 0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [CH*W-1:0] s, input logic [CH*W-1:0] r,
                                input logic [CH-1:0] g, input logic [CH*W-1:0] d);
    bus.s = s;
    bus.r = r;
    bus.g = g;
    bus.d = d;
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_val[c] = INIT[c*W +: W];
      m_gd[c]  = 1'b0;
      m_age[c] = 0;
    end
    m_closed  = '0;
    m_changed = '0;
  endfunction

  // Word-level rule: clear wins, then set, then gated data, else keep.
  function automatic logic [W-1:0] model_next(input int c);
    logic [W-1:0] sc, rc, dc;
    sc = bus.s[c*W +: W];
    rc = bus.r[c*W +: W];
    dc = bus.d[c*W +: W];
    return ~rc & (sc | (bus.g[c] ? dc : m_val[c]));
  endfunction

  function automatic logic [CH*W-1:0] model_q();
    logic [CH*W-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) begin
      if (reset)        v[c*W +: W] = INIT[c*W +: W];
      else if (MODE[c]) v[c*W +: W] = m_val[c];
      else              v[c*W +: W] = model_next(c);
    end
    return v;
  endfunction

  function automatic logic [CH*AGE_W-1:0] model_age();
    logic [CH*AGE_W-1:0] v;
    v = '0;
`ifdef LATCH_BANK_AGE_EN
    for (int c = 0; c < CH; c++) v[c*AGE_W +: AGE_W] = m_age[c][AGE_W-1:0];
`endif
    return v;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] nv [CH];
    logic         ld;
    for (int c = 0; c < CH; c++) nv[c] = model_next(c);
    for (int c = 0; c < CH; c++) begin
      ld = bus.g[c] || (bus.s[c*W +: W] != '0) || (bus.r[c*W +: W] != '0);
      m_closed[c]  = m_gd[c] && !bus.g[c];
      m_changed[c] = (nv[c] != m_val[c]);
      m_age[c]     = ld ? 0 : ((m_age[c] < AGE_MAX) ? m_age[c] + 1 : AGE_MAX);
      m_val[c]     = nv[c];
      m_gd[c]      = bus.g[c];
    end
  endfunction

  task automatic do_cycle(input string tag);
    #1;
    check_output({tag, "/q"}, bus.q, model_q());
    @(posedge clock);
    if (!reset) model_edge();
    #1;
    check_output({tag, "/closed"},  bus.closed,  m_closed);
    check_output({tag, "/changed"}, bus.changed, m_changed);
    check_output({tag, "/age"},     bus.age,     model_age());
  endtask

  // Raises reset mid-cycle, checks the async clear, releases between edges.
  task automatic pulse_reset(input string tag, input logic [CH-1:0] g_release);
    reset = 1'b1;
    #1;
    model_reset();
    check_output({tag, "/rst_q"},       bus.q,       INIT);
    check_output({tag, "/rst_closed"},  bus.closed,  '0);
    check_output({tag, "/rst_changed"}, bus.changed, '0);
    check_output({tag, "/rst_age"},     bus.age,     '0);
    @(posedge clock);
    bus.g = g_release;
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [CH*W-1:0] rs, rr, rd;
    logic [CH-1:0]   rg;
    logic [3:0]      exp_age;

    reset = 1'b1;
    apply_stimulus('0, '0, '0, '0);
    model_reset();
    #3;
    pulse_reset("init", '0);

    // Gate low: INIT value on ch0 stays put while d toggles
    for (int i = 0; i < 3; i++) begin
      apply_stimulus('0, '0, '0, (i % 2 == 0) ? 32'hFFFFFFFF : 32'h00000000);
      do_cycle("t1");
      check_output("t1_q0", bus.q[7:0], 8'hA5);
    end

    // Transparent ch0 open, then close with data held, then data moves
    apply_stimulus('0, '0, 4'b0001, 32'h0000003C);
    #1 check_output("t2_open_q0", bus.q[7:0], 8'h3C);
    do_cycle("t2a");
    check_output("t2a_changed0", bus.changed[0], 1'b1);
    apply_stimulus('0, '0, 4'b0000, 32'h0000003C);
    do_cycle("t2b");
    check_output("t2b_closed0", bus.closed[0], 1'b1);
    check_output("t2b_changed0", bus.changed[0], 1'b0);
    apply_stimulus('0, '0, 4'b0000, 32'h000000FF);
    do_cycle("t2c");
    check_output("t2c_q0", bus.q[7:0], 8'h3C);
    check_output("t2c_closed0", bus.closed[0], 1'b0);

    // Flop ch1: one cycle of latency
    apply_stimulus('0, '0, 4'b0010, 32'h00001200);
    #1 check_output("t3_pre_q1", bus.q[15:8], 8'h5A);
    do_cycle("t3");
    check_output("t3_post_q1", bus.q[15:8], 8'h12);

    // Set and reset together on transparent ch2: reset wins
    apply_stimulus(32'h00FF0000, 32'h00FF0000, 4'b0100, 32'h00550000);
    #1 check_output("t4_sr_q2", bus.q[23:16], 8'h00);
    do_cycle("t4a");
    apply_stimulus(32'h000F0000, '0, 4'b0000, 32'h00550000);
    #1 check_output("t4_s_q2", bus.q[23:16], 8'h0F);
    do_cycle("t4b");

    // Hold-age on ch3: load, idle 20 edges, then reload
    apply_stimulus('0, '0, 4'b1000, 32'hAB000000);
    do_cycle("t5load");
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus('0, '0, '0, 32'h12345678);
      do_cycle("t5idle");
`ifdef LATCH_BANK_AGE_EN
      exp_age = (i > 15) ? 4'd15 : 4'(i);
`else
      exp_age = 4'd0;
`endif
      check_output("t5_age3", bus.age[15:12], exp_age);
    end
    apply_stimulus('0, '0, 4'b1000, 32'hAB000000);
    do_cycle("t5reload");
    check_output("t5_age3_clr", bus.age[15:12], 4'd0);

    // Reset while ch0 is open and transparent
    apply_stimulus('0, '0, 4'b0001, 32'h00000077);
    #1 check_output("t6_open_q0", bus.q[7:0], 8'h77);
    pulse_reset("t6", 4'b0000);
    do_cycle("t6post");
    check_output("t6_closed", bus.closed, 4'b0000);

    // Randomized traffic with sparse set/reset and occasional async reset
    for (int i = 0; i < 400; i++) begin
      rs = $urandom & $urandom & $urandom;
      rr = $urandom & $urandom & $urandom;
      rd = $urandom;
      for (int c = 0; c < CH; c++) rg[c] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        rs = '0;
        rr = '0;
      end
      apply_stimulus(rs, rr, rg, rd);
      if ($urandom_range(0, 63) == 0)
        pulse_reset("rnd", 4'($urandom));
      do_cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
